// File: rtl/vscale_hasti_sram_slave.sv
//------------------------------------------------------------------------------
// vscale_hasti_sram_slave : AHB-Lite (HASTI) SRAM slave with wait states and error response
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vscale_hasti_sram_slave #(
   parameter int NWORDS      = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic        hmastlock,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp
);

   localparam int AW = $clog2(NWORDS);
   localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DATA = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    count, count_nxt;
   logic [AW-1:0] d_idx;
   logic [1:0]    d_off;
   logic [1:0]    d_size;
   logic          d_write;
   logic [3:0]    byte_en;
   logic          active, addr_err, size_err, xfer_err, take_xfer;

   logic [31:0] mem [NWORDS];

   logic unused_ok;
   assign unused_ok = ^{hburst, hmastlock, hprot, htrans[0]};

   assign active   = htrans[1];
   assign addr_err = (haddr[31:AW+2] != '0);
   assign size_err = (hsize > 3'd2) ||
                     ((hsize == 3'd1) && haddr[0]) ||
                     ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
   assign xfer_err  = addr_err || size_err;
   assign take_xfer = hready && active && !xfer_err;

   assign hready = !((state == S_WAIT) || (state == S_ERR1));
   assign hresp  = (state == S_ERR1) || (state == S_ERR2);
   assign hrdata = (((state == S_WAIT) || (state == S_DATA)) && !d_write) ? mem[d_idx] : 32'd0;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state   <= S_IDLE;
         count   <= 3'd0;
         d_idx   <= '0;
         d_off   <= 2'b00;
         d_size  <= 2'b00;
         d_write <= 1'b0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (take_xfer) begin
            d_idx   <= haddr[AW+1:2];
            d_off   <= haddr[1:0];
            d_size  <= hsize[1:0];
            d_write <= hwrite;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      case (state)
         S_IDLE, S_DATA, S_ERR2: begin
            if (!active) begin
               state_nxt = S_IDLE;
            end else if (xfer_err) begin
               state_nxt = S_ERR1;
            end else if (WAIT_STATES > 0) begin
               state_nxt = S_WAIT;
               count_nxt = WAIT_LOAD;
            end else begin
               state_nxt = S_DATA;
            end
         end
         S_WAIT: begin
            if (count == 3'd0) state_nxt = S_DATA;
            else               count_nxt = count - 3'd1;
         end
         S_ERR1:  state_nxt = S_ERR2;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      byte_en = 4'b0000;
      case (d_size)
         2'd0:    byte_en[d_off] = 1'b1;
         2'd1:    byte_en = d_off[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   // Storage has no reset; a reset during a data phase leaves state != DATA, so nothing commits.
   always_ff @(posedge hclk) begin
      if ((state == S_DATA) && d_write) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) mem[d_idx][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/vscale_hasti_sram_slave.md
VSCALE_HASTI_SRAM_SLAVE -- requirements
Module: vscale_hasti_sram_slave

Interface
REQ-001 SHALL have parameter NWORDS, default 1024, storage depth in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 0, number of hready-low cycles inserted per OKAY data phase (0..7).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: hclk input 1 (rising-edge clock); hresetn input 1 (async active-low reset).
REQ-004 SHALL have port haddr, input, 32, address-phase byte address.
REQ-005 SHALL have port hwrite, input, 1, address-phase write flag.
REQ-006 SHALL have port hsize, input, 3, address-phase transfer size (0 byte, 1 halfword, 2 word).
REQ-007 SHALL have port hburst, input, 3, burst type; ignored.
REQ-008 SHALL have port hmastlock, input, 1, lock; ignored.
REQ-009 SHALL have port hprot, input, 4, protection; ignored.
REQ-010 SHALL have port htrans, input, 2, transfer type (IDLE 0, BUSY 1, NONSEQ 2, SEQ 3).
REQ-011 SHALL have port hwdata, input, 32, data-phase write data.
REQ-012 SHALL have port hrdata, output, 32, data-phase read data.
REQ-013 SHALL have port hready, output, 1, transfer-done / bus-ready (sole slave on the bus).
REQ-014 SHALL have port hresp, output, 1, response (0 OKAY, 1 ERROR).

Function
REQ-015 SHALL sample the address phase (haddr, hwrite, hsize, htrans) only on a rising edge where its own hready is 1.
REQ-016 SHALL treat htrans NONSEQ or SEQ as an active transfer; IDLE and BUSY SHALL produce a zero-wait OKAY data phase with no storage access.
REQ-017 SHALL flag an active transfer as erroneous when haddr >= 4*NWORDS, hsize > 2, hsize==1 with haddr[0]==1, or hsize==2 with haddr[1:0]!=0.
REQ-018 SHALL implement states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-019 IDLE: hready=1, hresp=0; on a sampled active, error-free transfer SHALL go to WAIT (load counter = WAIT_STATES-1) if WAIT_STATES>0, else to DATA.
REQ-020 On a sampled erroneous transfer from any hready=1 state, SHALL go to ERR1.
REQ-021 WAIT: hready=0, hresp=0; SHALL decrement the counter and go to DATA on the edge where the counter is 0.
REQ-022 DATA: hready=1, hresp=0; SHALL complete the access on the next edge and go to the state selected by the concurrently sampled address phase (back-to-back transfers with no idle cycle).
REQ-023 ERR1: hready=0, hresp=1; SHALL unconditionally go to ERR2 next.
REQ-024 ERR2: hready=1, hresp=1; SHALL sample the next address phase like DATA.
REQ-025 Writes SHALL commit to storage on the edge ending DATA, using hwdata of that cycle, byte lanes enabled as follows: byte haddr[1:0]; halfword bytes {2*haddr[1], 2*haddr[1]+1}; word all four.
REQ-026 Word index SHALL be haddr[log2(NWORDS)+1:2]; hwdata lane mapping SHALL be little-endian (byte 0 = bits 7:0).
REQ-027 hrdata SHALL equal the full addressed storage word during WAIT and DATA of a read, and 0 at all other times.
REQ-028 A read whose data phase follows a write data phase to the same word SHALL return the newly written bytes.
REQ-029 Erroneous transfers SHALL never modify storage.
REQ-030 hburst, hmastlock and hprot SHALL have no effect on behaviour.

Reset
REQ-031 While hresetn=0, SHALL hold state IDLE, hready=1, hresp=0, hrdata=0 and counter=0, asserted asynchronously.
REQ-032 Reset asserted mid-transfer SHALL abort it; a pending write SHALL NOT commit.
REQ-033 Storage contents SHALL NOT be reset; they are undefined until written.

Verification
REQ-034 WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x10, then NONSEQ word read of 0x10 -> hready stays 1, read data phase hrdata=0xDEADBEEF, hresp=0.
REQ-035 WAIT_STATES=2: word read of 0x20 -> hready 0,0,1 over the three data-phase cycles, hrdata valid in the last, hresp=0 throughout.
REQ-036 Word 0x30 = 0x11223344; byte write 0xAA.. to 0x31, then halfword write 0xBEEF at 0x32 -> read of 0x30 returns 0xBEEFAA44.
REQ-037 NWORDS=1024: word write to 0x1000, and halfword to 0x41 -> each gives hready/hresp = (0,1) then (1,1), storage unchanged.
REQ-038 Back-to-back writes 0x1, 0x2, 0x3 to 0x0,0x4,0x8, then reads -> no idle cycles needed, returned values 1,2,3.
REQ-039 Assert hresetn low during WAIT of a write to 0x40 (WAIT_STATES=3) -> hready=1, hresp=0 immediately; subsequent read of 0x40 returns the pre-write value.
